// File: rtl/branch_ctrl_if.sv
// ==========================================================================
// branch_ctrl_if : MEM-stage branch-control signal bundle (tb/core <-> branch_ctrl)
// Revision: 1.0
// ==========================================================================
`default_nettype none

interface branch_ctrl_if #(
  parameter int AW    = 32,
  parameter int CNT_W = 16
);
  logic             stall;
  logic             bbne;
  logic             bbeq;
  logic             bblez;
  logic             bbgtz;
  logic             jump;
  logic             zero;
  logic             neg;
  logic [AW-1:0]    br_target;
  logic [AW-1:0]    j_target;
  logic             pc_load;
  logic [AW-1:0]    pc_target;
  logic             flush_ifid;
  logic             flush_idex;
  logic             flush_exmem;
  logic             busy;
  logic [CNT_W-1:0] taken_cnt;
  logic             multi_err;

  modport master (
    output stall, bbne, bbeq, bblez, bbgtz, jump, zero, neg, br_target, j_target,
    input  pc_load, pc_target, flush_ifid, flush_idex, flush_exmem, busy, taken_cnt, multi_err
  );

  modport slave (
    input  stall, bbne, bbeq, bblez, bbgtz, jump, zero, neg, br_target, j_target,
    output pc_load, pc_target, flush_ifid, flush_idex, flush_exmem, busy, taken_cnt, multi_err
  );
endinterface

`default_nettype wire

// File: rtl/branch_ctrl.sv
// ==========================================================================
// branch_ctrl : MEM-stage branch/jump resolve, PC redirect and pipeline flush
// Revision: 1.0
// ==========================================================================
`default_nettype none

module branch_ctrl #(
  parameter int AW            = 32,
  parameter int SQUASH_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  wire            clk,
  input  wire            rst_n,
  branch_ctrl_if.slave   bus
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_SQUASH = 1'b1;
  localparam logic [3:0] c_SQ     = 4'(SQUASH_CYCLES);

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [3:0]       r_sq_cnt;
  logic [3:0]       w_sq_nxt;
  logic [CNT_W-1:0] r_taken_cnt;
  logic             r_multi_err;

  logic             w_taken;
  logic [AW-1:0]    w_target;
  logic             w_multi;
  logic             w_redirect;
  logic             w_pc_load;
  logic [AW-1:0]    w_pc_target;
  logic             w_flush_ifid;
  logic             w_flush_back;

  // Priority: jump > bbeq > bbne > bblez > bbgtz
  always_comb begin
    w_taken  = 1'b0;
    w_target = '0;
    if (bus.jump) begin
      w_taken  = 1'b1;
      w_target = bus.j_target;
    end else if (bus.bbeq) begin
      w_taken  = bus.zero;
      w_target = bus.br_target;
    end else if (bus.bbne) begin
      w_taken  = ~bus.zero;
      w_target = bus.br_target;
    end else if (bus.bblez) begin
      w_taken  = bus.zero | bus.neg;
      w_target = bus.br_target;
    end else if (bus.bbgtz) begin
      w_taken  = ~bus.zero & ~bus.neg;
      w_target = bus.br_target;
    end
  end

  assign w_multi    = ($countones({bus.jump, bus.bbeq, bus.bbne, bus.bblez, bus.bbgtz}) > 1);
  assign w_redirect = (r_state == S_IDLE) & ~bus.stall & w_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sq_cnt    <= 4'd0;
      r_taken_cnt <= '0;
      r_multi_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sq_cnt <= w_sq_nxt;
      if (w_redirect) begin
        r_taken_cnt <= r_taken_cnt + CNT_W'(1);
      end
      if ((r_state == S_IDLE) && !bus.stall && w_multi) begin
        r_multi_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sq_nxt    = r_sq_cnt;
    if (!bus.stall) begin
      case (r_state)
        S_IDLE: begin
          if (w_taken && (c_SQ != 4'd0)) begin
            w_state_nxt = S_SQUASH;
            w_sq_nxt    = c_SQ;
          end
        end
        S_SQUASH: begin
          if (r_sq_cnt <= 4'd1) begin
            w_state_nxt = S_IDLE;
            w_sq_nxt    = 4'd0;
          end else begin
            w_sq_nxt    = r_sq_cnt - 4'd1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_sq_nxt    = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    w_pc_load    = 1'b0;
    w_pc_target  = '0;
    w_flush_ifid = 1'b0;
    w_flush_back = 1'b0;
    if (!bus.stall) begin
      case (r_state)
        S_IDLE: begin
          if (w_taken) begin
            w_pc_load    = 1'b1;
            w_pc_target  = w_target;
            w_flush_ifid = 1'b1;
            w_flush_back = 1'b1;
          end
        end
        S_SQUASH: begin
          w_flush_ifid = 1'b1;
        end
        default: begin
          w_flush_ifid = 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_load     = w_pc_load;
  assign bus.pc_target   = w_pc_target;
  assign bus.flush_ifid  = w_flush_ifid;
  assign bus.flush_idex  = w_flush_back;
  assign bus.flush_exmem = w_flush_back;
  assign bus.busy        = (r_state == S_SQUASH);
  assign bus.taken_cnt   = r_taken_cnt;
  assign bus.multi_err   = r_multi_err;

endmodule

`default_nettype wire

// File: tb/tb_branch_ctrl.sv
// ==========================================================================
// tb_branch_ctrl : scoreboard bench, two configs (SQ=1/CNT_W=16, SQ=3/CNT_W=4)
// Revision: 1.0
// ==========================================================================
`default_nettype none

module tb_branch_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        stall = 0, jump = 0, bbeq = 0, bbne = 0, bblez = 0, bbgtz = 0, zero = 0, neg = 0;
  logic [31:0] br_target = 0, j_target = 0;

  branch_ctrl_if #(.AW(32), .CNT_W(16)) bus1 ();
  branch_ctrl_if #(.AW(32), .CNT_W(4))  bus2 ();

  assign bus1.stall = stall;  assign bus2.stall = stall;
  assign bus1.jump  = jump;   assign bus2.jump  = jump;
  assign bus1.bbeq  = bbeq;   assign bus2.bbeq  = bbeq;
  assign bus1.bbne  = bbne;   assign bus2.bbne  = bbne;
  assign bus1.bblez = bblez;  assign bus2.bblez = bblez;
  assign bus1.bbgtz = bbgtz;  assign bus2.bbgtz = bbgtz;
  assign bus1.zero  = zero;   assign bus2.zero  = zero;
  assign bus1.neg   = neg;    assign bus2.neg   = neg;
  assign bus1.br_target = br_target;  assign bus2.br_target = br_target;
  assign bus1.j_target  = j_target;   assign bus2.j_target  = j_target;

  branch_ctrl #(.AW(32), .SQUASH_CYCLES(1), .CNT_W(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  branch_ctrl #(.AW(32), .SQUASH_CYCLES(3), .CNT_W(4))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  typedef struct { int sq_left; int cnt; bit err; } mdl_t;
  typedef struct packed {
    logic pcl; logic [31:0] tgt; logic fi; logic fd; logic fe; logic busy; logic [15:0] cnt; logic err;
  } exp_t;

  mdl_t m1, m2;
  exp_t q1[$], q2[$];
  int total = 0, bad = 0;

  function automatic int nflags();
    return int'(jump) + int'(bbeq) + int'(bbne) + int'(bblez) + int'(bbgtz);
  endfunction

  function automatic bit is_taken();
    if (jump)  return 1;
    if (bbeq)  return zero;
    if (bbne)  return !zero;
    if (bblez) return zero || neg;
    if (bbgtz) return !zero && !neg;
    return 0;
  endfunction

  function automatic mdl_t reset_mdl();
    mdl_t m;
    m.sq_left = 0; m.cnt = 0; m.err = 0;
    return m;
  endfunction

  // Advance the model across one clock edge using the inputs held during that cycle.
  function automatic mdl_t next_of(mdl_t m, int sq, int w);
    mdl_t r = m;
    if (stall) return r;
    if (m.sq_left > 0) begin
      r.sq_left = m.sq_left - 1;
    end else begin
      if (nflags() >= 2) r.err = 1;
      if (is_taken()) begin
        r.cnt = (m.cnt + 1) % (1 << w);
        r.sq_left = sq;
      end
    end
    return r;
  endfunction

  function automatic exp_t expect_of(mdl_t m);
    exp_t e;
    bit idle = (m.sq_left == 0);
    bit redir = idle && !stall && is_taken();
    e.pcl  = redir;
    e.tgt  = redir ? (jump ? j_target : br_target) : 32'd0;
    e.fd   = redir;
    e.fe   = redir;
    e.fi   = redir || (!idle && !stall);
    e.busy = !idle;
    e.cnt  = 16'(m.cnt);
    e.err  = m.err;
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: advance model over the edge, apply inputs, queue expectations.
  task automatic cyc(bit rn, bit st, bit [4:0] f, bit z, bit n, logic [31:0] bt, logic [31:0] jt);
    @(posedge clk);
    #1;
    if (rst_n) begin
      m1 = next_of(m1, 1, 16);
      m2 = next_of(m2, 3, 4);
    end
    rst_n = rn; stall = st;
    {jump, bbeq, bbne, bblez, bbgtz} = f;
    zero = z; neg = n; br_target = bt; j_target = jt;
    if (!rn) begin
      m1 = reset_mdl();
      m2 = reset_mdl();
    end
    q1.push_back(expect_of(m1));
    q2.push_back(expect_of(m2));
  endtask

  task automatic idle(int k);
    for (int i = 0; i < k; i++) cyc(1, 0, 5'b0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("d1.pc_load",   64'(bus1.pc_load),     64'(e.pcl));
        chk("d1.pc_target", 64'(bus1.pc_target),   64'(e.tgt));
        chk("d1.flush_ifid", 64'(bus1.flush_ifid), 64'(e.fi));
        chk("d1.flush_idex", 64'(bus1.flush_idex), 64'(e.fd));
        chk("d1.flush_exmem", 64'(bus1.flush_exmem), 64'(e.fe));
        chk("d1.busy",      64'(bus1.busy),        64'(e.busy));
        chk("d1.taken_cnt", 64'(bus1.taken_cnt),   64'(e.cnt));
        chk("d1.multi_err", 64'(bus1.multi_err),   64'(e.err));
      end
      if (q2.size() > 0) begin
        e = q2.pop_front();
        chk("d2.pc_load",   64'(bus2.pc_load),     64'(e.pcl));
        chk("d2.pc_target", 64'(bus2.pc_target),   64'(e.tgt));
        chk("d2.flush_ifid", 64'(bus2.flush_ifid), 64'(e.fi));
        chk("d2.flush_idex", 64'(bus2.flush_idex), 64'(e.fd));
        chk("d2.flush_exmem", 64'(bus2.flush_exmem), 64'(e.fe));
        chk("d2.busy",      64'(bus2.busy),        64'(e.busy));
        chk("d2.taken_cnt", 64'(bus2.taken_cnt),   64'(e.cnt));
        chk("d2.multi_err", 64'(bus2.multi_err),   64'(e.err));
      end
    end
  end

  initial begin : stim
    bit [4:0] f;
    m1 = reset_mdl();
    m2 = reset_mdl();
    cyc(0, 0, 5'b0, 0, 0, 32'h0, 32'h0);
    cyc(0, 0, 5'b01000, 1, 0, 32'h0040_0020, 32'h0);
    // flag order: {jump, bbeq, bbne, bblez, bbgtz}
    cyc(1, 0, 5'b01000, 1, 0, 32'h0040_0020, 32'h0);
    idle(4);
    cyc(1, 0, 5'b00100, 1, 0, 32'h0000_0400, 32'h0);
    cyc(1, 0, 5'b00001, 0, 0, 32'h0000_0500, 32'h0);
    idle(4);
    cyc(1, 0, 5'b00010, 0, 1, 32'h0000_0600, 32'h0);
    idle(4);
    cyc(1, 0, 5'b11000, 1, 0, 32'h0000_2000, 32'h0000_1000);
    idle(10);
    for (int i = 0; i < 3; i++) cyc(1, 1, 5'b10000, 0, 0, 32'h0, 32'h0000_3000);
    cyc(1, 0, 5'b10000, 0, 0, 32'h0, 32'h0000_3000);
    cyc(1, 1, 5'b0, 0, 0, 32'h0, 32'h0);
    cyc(1, 1, 5'b0, 0, 0, 32'h0, 32'h0);
    idle(5);
    cyc(1, 0, 5'b10000, 0, 0, 32'h0, 32'h0000_4000);
    cyc(1, 0, 5'b0, 0, 0, 32'h0, 32'h0);
    cyc(0, 0, 5'b0, 0, 0, 32'h0, 32'h0);
    idle(4);
    for (int i = 0; i < 72; i++) cyc(1, 0, 5'b10000, 0, 0, 32'h0, 32'h100 + 32'(i));
    idle(4);
    for (int i = 0; i < 700; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: f = 5'b0;
        3:       f = 5'($urandom_range(0, 31));
        default: f = 5'b1 << $urandom_range(0, 4);
      endcase
      cyc(($urandom_range(0, 149) != 0), ($urandom_range(0, 4) == 0), f,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
    end
    idle(3);
    @(negedge clk);
    #1;
    chk("queue_drained", 64'(q1.size() + q2.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
